// File: rtl/bram_line_requester_if.sv
// Line request/response channels between a cache controller (master)
// and the BRAM line requester (slave).
interface bram_line_requester_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4
);
    logic                                 req_valid;
    logic                                 req_ready;
    logic                                 req_write;
    logic [ADDR_WIDTH-1:0]                req_address;
    logic [DATA_WIDTH*WORDS_PER_LINE-1:0] req_data;
    logic                                 resp_valid;
    logic                                 resp_ready;
    logic                                 resp_write;
    logic [DATA_WIDTH*WORDS_PER_LINE-1:0] resp_data;

    modport master (
        output req_valid, req_write, req_address, req_data, resp_ready,
        input  req_ready, resp_valid, resp_write, resp_data
    );

    modport slave (
        input  req_valid, req_write, req_address, req_data, resp_ready,
        output req_ready, resp_valid, resp_write, resp_data
    );
endinterface

// File: rtl/bram_line_requester.sv
// Serialises whole-line cache reads/writes into single-word accesses on one
// port of a block RAM with a one-cycle registered read.
module bram_line_requester #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int OFFSET_BITS    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    bram_line_requester_if.slave  bus,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);
    localparam int CW = OFFSET_BITS + 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESPOND} state_t;

    state_t                                        state;
    logic [CW-1:0]                                 cnt;
    logic [ADDR_WIDTH-1:0]                         base;
    logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0]     wr_line;
    logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0]     rd_line;
    logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0]     rd_line_nxt;
    logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0]     resp_line;
    logic                                          resp_valid_q;
    logic                                          resp_write_q;
    logic [OFFSET_BITS-1:0]                        wr_idx;
    logic [OFFSET_BITS-1:0]                        rd_idx;

    assign wr_idx = cnt[OFFSET_BITS-1:0];
    // Read data lags the address by one beat; wraps to the last word on the drain beat.
    assign rd_idx = wr_idx - OFFSET_BITS'(1);

    assign bus.req_ready  = (state == IDLE) && !reset;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_write = resp_write_q;
    assign bus.resp_data  = resp_line;

    always_comb begin
        rd_line_nxt = rd_line;
        if (cnt != '0)
            rd_line_nxt[rd_idx] = mem_data_out;
    end

    always_comb begin
        mem_we      = 1'b0;
        mem_address = '0;
        mem_data_in = '0;
        case (state)
            WRITE: begin
                mem_we      = 1'b1;
                mem_address = base + ADDR_WIDTH'(cnt);
                mem_data_in = wr_line[wr_idx];
            end
            READ: begin
                if (cnt != CW'(WORDS_PER_LINE))
                    mem_address = base + ADDR_WIDTH'(cnt);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            base         <= '0;
            wr_line      <= '0;
            rd_line      <= '0;
            resp_line    <= '0;
            resp_valid_q <= 1'b0;
            resp_write_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        base         <= bus.req_address & ~ADDR_WIDTH'(WORDS_PER_LINE - 1);
                        wr_line      <= bus.req_data;
                        resp_write_q <= bus.req_write;
                        cnt          <= '0;
                        state        <= bus.req_write ? WRITE : READ;
                    end
                end
                WRITE: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WORDS_PER_LINE - 1)) begin
                        state        <= RESPOND;
                        resp_valid_q <= 1'b1;
                    end
                end
                READ: begin
                    rd_line <= rd_line_nxt;
                    cnt     <= cnt + CW'(1);
                    if (cnt == CW'(WORDS_PER_LINE)) begin
                        state        <= RESPOND;
                        resp_valid_q <= 1'b1;
                        resp_line    <= rd_line_nxt;
                    end
                end
                RESPOND: begin
                    if (bus.resp_ready) begin
                        state        <= IDLE;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_line_requester.sv
// Directed bench: line requests from a vector table against a behavioural BRAM,
// plus a hand-written mid-write reset sequence.
module tb_bram_line_requester;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int W  = 4;
    localparam int OB = 2;
    localparam int LW = DW * W;

    logic          clock = 1'b0;
    logic          reset;
    logic          mem_we;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;
    logic [DW-1:0] ram [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    bram_line_requester_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORDS_PER_LINE(W)) bus ();

    bram_line_requester #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORDS_PER_LINE(W), .OFFSET_BITS(OB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .mem_we       (mem_we),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    always @(posedge clock) begin
        if (mem_we) ram[mem_address[7:0]] <= mem_data_in;
        mem_data_out <= ram[mem_address[7:0]];
    end

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] line;
        int            hold;
        int            exp_lat;
        logic [LW-1:0] exp_data;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [LW-1:0] mk_line(input logic [DW-1:0] b);
        logic [LW-1:0] l;
        for (int i = 0; i < W; i++) l[i*DW +: DW] = b + DW'(i);
        return l;
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run(input vec_t v);
        logic [AW-1:0] b;
        logic [LW-1:0] snap;
        int lat;
        b = v.addr & ~AW'(W - 1);
        bus.req_valid   = 1'b1;
        bus.req_write   = v.wr;
        bus.req_address = v.addr;
        bus.req_data    = v.line;
        chk("req_ready_idle", LW'(bus.req_ready), LW'(1));
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (k <= W) begin
                chk("mem_we", LW'(mem_we), LW'(v.wr));
                chk("mem_address", LW'(mem_address), LW'(b + AW'(k - 1)));
                if (v.wr) chk("mem_data_in", LW'(mem_data_in), LW'(v.line[(k-1)*DW +: DW]));
            end
            if (!v.wr && k == W + 1) chk("drain_address", LW'(mem_address), LW'(0));
            if (bus.resp_valid) begin
                lat = k;
                break;
            end
        end
        chk("latency", LW'(lat), LW'(v.exp_lat));
        chk("resp_write", LW'(bus.resp_write), LW'(v.wr));
        chk("resp_data", bus.resp_data, v.exp_data);
        snap = bus.resp_data;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clock);
            chk("hold_resp_valid", LW'(bus.resp_valid), LW'(1));
            chk("hold_resp_data", bus.resp_data, snap);
            chk("hold_req_ready", LW'(bus.req_ready), LW'(0));
            chk("hold_mem_we", LW'(mem_we), LW'(0));
        end
        bus.resp_ready = 1'b1;
        @(negedge clock);
        bus.resp_ready = 1'b0;
        chk("post_resp_valid", LW'(bus.resp_valid), LW'(0));
        chk("post_req_ready", LW'(bus.req_ready), LW'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] la, lb, lc, ld, mixed;
        vec_t v;
        for (int i = 0; i < 256; i++) ram[i] = '0;
        la = mk_line(32'hA0);
        lb = mk_line(32'hB0);
        lc = mk_line(32'hC0);
        ld = mk_line(32'hD0);
        mixed = lc;
        mixed[0 +: 2*DW] = ld[0 +: 2*DW];

        vecs[0] = '{1'b1, 32'h10, la, 0, 5, '0};
        vecs[1] = '{1'b0, 32'h10, '0, 5, 6, la};
        vecs[2] = '{1'b0, 32'h13, '0, 0, 6, la};
        vecs[3] = '{1'b1, 32'h40, lb, 0, 5, la};
        vecs[4] = '{1'b0, 32'h40, '0, 0, 6, lb};
        vecs[5] = '{1'b1, 32'h20, lc, 0, 5, lb};

        reset           = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_address = '0;
        bus.req_data    = '0;
        bus.resp_ready  = 1'b0;
        repeat (3) @(negedge clock);
        chk("req_ready_in_reset", LW'(bus.req_ready), LW'(0));
        reset = 1'b0;
        @(negedge clock);
        chk("rst_req_ready", LW'(bus.req_ready), LW'(1));
        chk("rst_resp_valid", LW'(bus.resp_valid), LW'(0));
        chk("rst_resp_write", LW'(bus.resp_write), LW'(0));
        chk("rst_resp_data", bus.resp_data, '0);
        chk("rst_mem_we", LW'(mem_we), LW'(0));
        chk("rst_mem_address", LW'(mem_address), LW'(0));

        for (int i = 0; i < 6; i++) run(vecs[i]);

        // Reset lands on the edge after the second write beat.
        bus.req_valid   = 1'b1;
        bus.req_write   = 1'b1;
        bus.req_address = 32'h20;
        bus.req_data    = ld;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(negedge clock);
        chk("rw_beat0_addr", LW'(mem_address), LW'(32'h20));
        chk("rw_beat0_we", LW'(mem_we), LW'(1));
        @(negedge clock);
        chk("rw_beat1_addr", LW'(mem_address), LW'(32'h21));
        reset = 1'b1;
        @(negedge clock);
        chk("rw_rst_mem_we", LW'(mem_we), LW'(0));
        chk("rw_rst_resp_valid", LW'(bus.resp_valid), LW'(0));
        chk("rw_rst_resp_data", bus.resp_data, '0);
        reset = 1'b0;
        @(negedge clock);
        chk("rw_req_ready", LW'(bus.req_ready), LW'(1));
        chk("rw_resp_valid", LW'(bus.resp_valid), LW'(0));
        chk("rw_mem_we", LW'(mem_we), LW'(0));

        v = '{1'b0, 32'h20, '0, 2, 6, mixed};
        run(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bram_line_requester.md
Name: bram_line_requester

Overview:
Initiator-side sequencer that drives one port of the dual-port block RAM on behalf of a cache. It accepts whole-line read or write requests from a cache controller over a valid/ready handshake. It serialises each request into WORDS_PER_LINE single-word accesses on the RAM port, accounting for the RAM's one-cycle registered read latency. It then returns the assembled line, or a write acknowledge, over a valid/ready response channel.

Parameters:
DATA_WIDTH, 32, width of one RAM word.
ADDR_WIDTH, 32, width of word address on both request and RAM port.
WORDS_PER_LINE, 4, words per cache line; power of two, 2..16.
OFFSET_BITS, 2, log2(WORDS_PER_LINE); must be consistent with WORDS_PER_LINE.

Ports:
clock  in  1  single clock; all state changes on rising edge.
reset  in  1  synchronous, active-high.
req_valid  in  1  request present.
req_ready  out  1  requester can accept a request.
req_write  in  1  1 = line write, 0 = line read.
req_address  in  ADDR_WIDTH  word address; low OFFSET_BITS ignored (line-aligned).
req_data  in  DATA_WIDTH*WORDS_PER_LINE  write line; word i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
resp_valid  out  1  response present.
resp_ready  in  1  consumer accepts response.
resp_write  out  1  echo of req_write for this response.
resp_data  out  DATA_WIDTH*WORDS_PER_LINE  read line, same packing as req_data.
mem_we  out  1  RAM port write enable.
mem_address  out  ADDR_WIDTH  RAM port word address.
mem_data_in  out  DATA_WIDTH  RAM port write data.
mem_data_out  in  DATA_WIDTH  RAM port registered read data; valid the cycle after address is presented.

Behaviour:
- States: IDLE, WRITE, READ, RESPOND. Beat counter cnt (OFFSET_BITS+1 bits). Base address base = req_address with low OFFSET_BITS cleared, captured on accept.
- Reset values: state IDLE, cnt 0, resp_valid 0, resp_write 0, resp_data 0, line buffer 0.
- req_ready = (state==IDLE) && !reset. Accept when req_valid && req_ready. Capture req_write, base and req_data. Go to WRITE or READ with cnt=0.
- WRITE: mem_we=1, mem_address=base+cnt, mem_data_in=req word[cnt]. cnt increments each cycle. After cnt==WORDS_PER_LINE-1, go to RESPOND.
- READ: for cnt 0..WORDS_PER_LINE-1, mem_we=0 and mem_address=base+cnt. For cnt 1..WORDS_PER_LINE, mem_data_out is stored into line word[cnt-1]. At cnt==WORDS_PER_LINE there is no address issue (drain cycle) and mem_address=0. After that capture, go to RESPOND.
- RESPOND: resp_valid=1; resp_write and resp_data are stable until resp_ready. resp_data holds the read line for reads. For writes, resp_data retains its previous value. On resp_valid && resp_ready, go to IDLE the next cycle.
- Outside WRITE: mem_we=0, mem_data_in=0. In IDLE and RESPOND: mem_address=0.
- Latency, request accepted at edge T:
  - Write: mem_we high for cycles T+1..T+W; resp_valid from T+W+1.
  - Read: addresses on cycles T+1..T+W, data captured T+2..T+W+1; resp_valid from T+W+2.
- Throughput: one request outstanding. A new request is accepted at the earliest one cycle after the response handshake; no overlap.
- Address arithmetic: base+cnt is computed modulo 2^ADDR_WIDTH. Alignment guarantees no carry out of the offset field.
- resp_ready asserted while not in RESPOND has no effect. req_valid outside IDLE is ignored; the request must be held by the source.
- Reset mid-operation: return to IDLE next edge; no further mem_we pulses. Words already written stay in RAM; the partial read line is discarded (buffer cleared); resp_valid drops.
- All outputs other than the state-decoded RAM port and req_ready are registered.

Test Plan:
- Write line at req_address 0x10, words {0xA0,0xA1,0xA2,0xA3} -> mem_we high 4 cycles at 0x10..0x13 with matching data; resp_valid at T+5, resp_write=1.
- Read line at 0x10 after RAM is preloaded with the above -> addresses 0x10..0x13 on T+1..T+4; resp_valid at T+6, resp_data={0xA3,0xA2,0xA1,0xA0} (word 0 in LSBs), resp_write=0.
- Unaligned read at 0x13 -> identical access pattern and data to the 0x10 read.
- Hold resp_ready low 5 cycles in RESPOND -> resp_valid and resp_data stable, req_ready=0, mem_we=0. Raise resp_ready -> IDLE next cycle.
- Assert reset at beat 2 of a write to 0x20 -> only 0x20,0x21 written; next cycle req_ready=1, resp_valid=0. A subsequent read of 0x20 returns new words 0 and 1 and old words 2 and 3.
- Back-to-back write to 0x40 then read from 0x40 with resp_ready tied high -> second request accepted one cycle after first handshake; read returns the written line.
